dma_reg_file: RTL and testbench

CPU-programmable register file for the 8237A-style DMA controller. Decodes 8-bit processor I/O cycles into writes and reads of the channel, command, mode, request, mask, status and temporary registers. Applies per-transfer address/word-count updates from the timing FSM and drives every field of the `dmaRegIf.REG` modport. The priority resolver and the FSM consume those fields through their own modports.

---
 rtl/dma_pkg.sv | 27 ++
 rtl/dmaRegIf.sv | 31 +++
 rtl/dma_cpu_access.sv | 66 ++++++
 rtl/dma_reg_file.sv | 170 +++++++++++++++++
 tb/tb_dma_reg_file.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA register file: the CPU address map, mode-bit
// positions and the reset value of the mask register.
package dma_pkg;

  typedef enum logic [3:0] {
    ADDR_CMD         = 4'h8,
    ADDR_REQ         = 4'h9,
    ADDR_MASK_SINGLE = 4'hA,
    ADDR_MODE        = 4'hB,
    ADDR_CLR_BP      = 4'hC,
    ADDR_MASTER_CLR  = 4'hD,
    ADDR_CLR_MASK    = 4'hE,
    ADDR_MASK_ALL    = 4'hF
  } dma_addr_e;

  // Read aliases share addresses with write-only registers.
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_TEMP   = 4'hD;

  localparam int MODE_AUTOINIT_BIT = 2;
  localparam int MODE_DEC_BIT      = 3;

  localparam logic [7:0] MASK_RESET = 8'h0F;

  typedef logic [5:0] dma_mode_t;

endpackage

// File: rtl/dmaRegIf.sv
// Register bundle exported by the DMA register file to the priority resolver
// and the transfer-timing FSM.
interface dmaRegIf;
  import dma_pkg::*;

  logic [3:0][15:0]  baseAddrReg;
  logic [3:0][15:0]  currAddrReg;
  logic [3:0][15:0]  baseWordReg;
  logic [3:0][15:0]  currWordReg;
  logic [7:0]        commandReg;
  logic [3:0]        requestReg;
  logic [7:0]        maskReg;
  dma_mode_t [3:0]   modeReg;
  logic [7:0]        statusReg;
  logic [7:0]        tempReg;

  modport REG (
    output baseAddrReg, currAddrReg, baseWordReg, currWordReg,
           commandReg, requestReg, maskReg, modeReg, statusReg, tempReg
  );

  modport PRI (
    input commandReg, requestReg, maskReg, statusReg
  );

  modport FSM (
    input baseAddrReg, currAddrReg, baseWordReg, currWordReg,
          commandReg, requestReg, maskReg, modeReg, statusReg, tempReg
  );

endinterface

// File: rtl/dma_cpu_access.sv
// CPU bus front end: registers the strobes, finds write-start / read-end edges,
// decodes the address into one-hot strobes and keeps the byte pointer.
module dma_cpu_access
  import dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS_N,
  input  logic        IOR_N,
  input  logic        IOW_N,
  input  logic [3:0]  A,
  output logic [15:0] o_wr_stb,
  output logic [15:0] o_rd_end,
  output logic        o_bp
);

  logic       w_wr_act;
  logic       w_rd_act;
  logic       w_wr_fire;
  logic       w_rd_fire;
  logic       r_wr_s;
  logic       r_wr_d;
  logic       r_rd_s;
  logic       r_rd_d;
  logic [3:0] r_rd_addr;
  logic       r_bp;

  assign w_wr_act = !CS_N && !IOW_N;
  assign w_rd_act = !CS_N && !IOR_N;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_s    <= 1'b0;
      r_wr_d    <= 1'b0;
      r_rd_s    <= 1'b0;
      r_rd_d    <= 1'b0;
      r_rd_addr <= 4'h0;
    end else begin
      r_wr_s <= w_wr_act;
      r_wr_d <= r_wr_s;
      r_rd_s <= w_rd_act;
      r_rd_d <= r_rd_s;
      // Read side effects land after the strobe, so remember which register was read.
      if (w_rd_act) r_rd_addr <= A;
    end
  end

  assign w_wr_fire = r_wr_s && !r_wr_d;
  assign w_rd_fire = !r_rd_s && r_rd_d;

  assign o_wr_stb = w_wr_fire ? (16'h0001 << A) : 16'h0000;
  assign o_rd_end = w_rd_fire ? (16'h0001 << r_rd_addr) : 16'h0000;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bp <= 1'b0;
    end else if (o_wr_stb[ADDR_CLR_BP] || o_wr_stb[ADDR_MASTER_CLR]) begin
      r_bp <= 1'b0;
    end else if ((|o_wr_stb[7:0]) || (|o_rd_end[7:0])) begin
      r_bp <= ~r_bp;
    end
  end

  assign o_bp = r_bp;

endmodule

// File: rtl/dma_reg_file.sv
// Register core of the 8237A-style DMA controller: CPU-programmed registers,
// per-transfer address/count updates and the CPU read-back mux.
module dma_reg_file
  import dma_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS_N,
  input  logic        IOR_N,
  input  logic        IOW_N,
  input  logic [3:0]  A,
  input  logic [7:0]  DB_in,
  output logic [7:0]  DB_out,
  output logic        DB_oe,
  input  logic [3:0]  dreq,
  input  logic        upd,
  input  logic [1:0]  upd_ch,
  output logic        tc,
  input  logic        temp_ld,
  input  logic [7:0]  temp_din,
  dmaRegIf.REG        regs
);

  logic [15:0]                w_wr_stb;
  logic [15:0]                w_rd_end;
  logic                       w_bp;
  logic                       w_mclr;
  logic [NCH-1:0]             w_commit_ch;
  logic [15:0]                w_rd_word;
  logic [7:0]                 w_rd_data;
  logic [1:0]                 w_ch;
  logic                       w_unused_stb;

  logic [NCH-1:0][15:0]       r_base_addr;
  logic [NCH-1:0][15:0]       r_curr_addr;
  logic [NCH-1:0][15:0]       r_base_word;
  logic [NCH-1:0][15:0]       r_curr_word;
  dma_mode_t [NCH-1:0]        r_mode;
  logic [7:0]                 r_cmd;
  logic [3:0]                 r_req;
  logic [7:0]                 r_mask;
  logic [3:0]                 r_tc_stat;
  logic [3:0]                 r_dreq;
  logic [7:0]                 r_temp;
  logic [7:0]                 r_temp_addr;
  logic [7:0]                 r_temp_word;

  dma_cpu_access u_cpu (
    .CLK      (CLK),
    .RESET    (RESET),
    .CS_N     (CS_N),
    .IOR_N    (IOR_N),
    .IOW_N    (IOW_N),
    .A        (A),
    .o_wr_stb (w_wr_stb),
    .o_rd_end (w_rd_end),
    .o_bp     (w_bp)
  );

  assign w_mclr       = w_wr_stb[ADDR_MASTER_CLR];
  assign w_unused_stb = ^{w_rd_end[15:9], w_rd_end[7:0], w_wr_stb[ADDR_CLR_BP]};

  // A high-byte commit owns the channel for that cycle; a coincident update is dropped.
  always_comb begin
    w_commit_ch = '0;
    for (int n = 0; n < NCH; n++) begin
      w_commit_ch[n] = w_bp && (w_wr_stb[2*n] || w_wr_stb[2*n+1]);
    end
  end

  assign tc = upd && (r_curr_word[upd_ch] == 16'h0000);

  always_ff @(posedge CLK) begin
    if (RESET || w_mclr) begin
      r_base_addr <= '0;
      r_curr_addr <= '0;
      r_base_word <= '0;
      r_curr_word <= '0;
      r_mode      <= '0;
      r_cmd       <= 8'h00;
      r_req       <= 4'h0;
      r_mask      <= MASK_RESET;
      r_tc_stat   <= 4'h0;
      r_temp      <= 8'h00;
      r_temp_addr <= 8'h00;
      r_temp_word <= 8'h00;
    end else begin
      if (temp_ld) r_temp <= temp_din;
      if (w_rd_end[ADDR_STATUS]) r_tc_stat <= 4'h0;

      if (upd && !w_commit_ch[upd_ch]) begin
        r_curr_addr[upd_ch] <= r_mode[upd_ch][MODE_DEC_BIT] ? r_curr_addr[upd_ch] - 16'd1
                                                             : r_curr_addr[upd_ch] + 16'd1;
        r_curr_word[upd_ch] <= r_curr_word[upd_ch] - 16'd1;
        if (tc) begin
          r_tc_stat[upd_ch] <= 1'b1;
          r_req[upd_ch]     <= 1'b0;
          if (r_mode[upd_ch][MODE_AUTOINIT_BIT]) begin
            r_curr_addr[upd_ch] <= r_base_addr[upd_ch];
            r_curr_word[upd_ch] <= r_base_word[upd_ch];
          end else begin
            r_mask[upd_ch] <= 1'b1;
          end
        end
      end

      for (int n = 0; n < NCH; n++) begin
        if (w_wr_stb[2*n]) begin
          if (!w_bp) begin
            r_temp_addr <= DB_in;
          end else begin
            r_base_addr[n] <= {DB_in, r_temp_addr};
            r_curr_addr[n] <= {DB_in, r_temp_addr};
          end
        end
        if (w_wr_stb[2*n+1]) begin
          if (!w_bp) begin
            r_temp_word <= DB_in;
          end else begin
            r_base_word[n] <= {DB_in, r_temp_word};
            r_curr_word[n] <= {DB_in, r_temp_word};
          end
        end
      end

      if (w_wr_stb[ADDR_CMD])         r_cmd <= DB_in;
      if (w_wr_stb[ADDR_REQ])         r_req[DB_in[1:0]] <= DB_in[2];
      if (w_wr_stb[ADDR_MASK_SINGLE]) r_mask[DB_in[1:0]] <= DB_in[2];
      if (w_wr_stb[ADDR_MODE])        r_mode[DB_in[1:0]] <= DB_in[7:2];
      if (w_wr_stb[ADDR_CLR_MASK])    r_mask[3:0] <= 4'h0;
      if (w_wr_stb[ADDR_MASK_ALL])    r_mask[3:0] <= DB_in[3:0];
    end
  end

  always_ff @(posedge CLK) begin
    r_dreq <= dreq;
  end

  assign w_ch = A[2:1];

  always_comb begin
    w_rd_word = 16'h0000;
    w_rd_data = 8'h00;
    if (!A[3]) begin
      w_rd_word = A[0] ? r_curr_word[w_ch] : r_curr_addr[w_ch];
      w_rd_data = w_bp ? w_rd_word[15:8] : w_rd_word[7:0];
    end else if (A == ADDR_STATUS) begin
      w_rd_data = {r_dreq, r_tc_stat};
    end else if (A == ADDR_TEMP) begin
      w_rd_data = r_temp;
    end
  end

  assign DB_oe  = !CS_N && !IOR_N;
  assign DB_out = DB_oe ? w_rd_data : 8'h00;

  assign regs.baseAddrReg = r_base_addr;
  assign regs.currAddrReg = r_curr_addr;
  assign regs.baseWordReg = r_base_word;
  assign regs.currWordReg = r_curr_word;
  assign regs.commandReg  = r_cmd;
  assign regs.requestReg  = r_req;
  assign regs.maskReg     = r_mask;
  assign regs.modeReg     = r_mode;
  assign regs.statusReg   = {r_dreq, r_tc_stat};
  assign regs.tempReg     = r_temp;

endmodule

// File: tb/tb_dma_reg_file.sv
// Self-checking bench for dma_reg_file: a table of CPU cycles plus hand-written
// transfer-update, coincidence and master-clear sequences.
module tb_dma_reg_file;

  logic       CLK;
  logic       RESET;
  logic       CS_N;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic [7:0] DB_in;
  logic [7:0] DB_out;
  logic       DB_oe;
  logic [3:0] dreq;
  logic       upd;
  logic [1:0] upd_ch;
  logic       tc;
  logic       temp_ld;
  logic [7:0] temp_din;

  dmaRegIf regs_if ();

  dma_reg_file #(.NCH(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CS_N     (CS_N),
    .IOR_N    (IOR_N),
    .IOW_N    (IOW_N),
    .A        (A),
    .DB_in    (DB_in),
    .DB_out   (DB_out),
    .DB_oe    (DB_oe),
    .dreq     (dreq),
    .upd      (upd),
    .upd_ch   (upd_ch),
    .tc       (tc),
    .temp_ld  (temp_ld),
    .temp_din (temp_din),
    .regs     (regs_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d,
                           input logic with_upd, input logic [1:0] ch);
    @(negedge CLK);
    A = a; DB_in = d; CS_N = 1'b0; IOW_N = 1'b0;
    @(negedge CLK);
    if (with_upd) begin upd = 1'b1; upd_ch = ch; end
    @(negedge CLK);
    upd = 1'b0;
    CS_N = 1'b1; IOW_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic cpu_read(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] want;
    @(negedge CLK);
    A = a; CS_N = 1'b0; IOR_N = 1'b0;
    sb_q.push_back(exp);
    #1;
    want = sb_q.pop_front();
    check({name, "_oe"}, {31'd0, DB_oe}, 32'd1);
    check(name, {24'd0, DB_out}, {24'd0, want});
    @(negedge CLK);
    CS_N = 1'b1; IOR_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic pulse_upd(input string name, input logic [1:0] ch, input logic exp_tc);
    logic want;
    @(negedge CLK);
    upd = 1'b1; upd_ch = ch;
    sb_q.push_back({7'd0, exp_tc});
    #1;
    want = sb_q.pop_front()[0];
    check(name, {31'd0, tc}, {31'd0, want});
    @(negedge CLK);
    upd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{1'b1, 4'h0, 8'h34, 8'h00};
    tbl[1] = '{1'b1, 4'h0, 8'h12, 8'h00};
    tbl[2] = '{1'b0, 4'h0, 8'h00, 8'h34};
    tbl[3] = '{1'b0, 4'h0, 8'h00, 8'h12};
    tbl[4] = '{1'b1, 4'h1, 8'hCD, 8'h00};
    tbl[5] = '{1'b1, 4'h1, 8'hAB, 8'h00};
    tbl[6] = '{1'b0, 4'h1, 8'h00, 8'hCD};
    tbl[7] = '{1'b0, 4'h1, 8'h00, 8'hAB};
    tbl[8] = '{1'b0, 4'h9, 8'h00, 8'h00};
    tbl[9] = '{1'b0, 4'hF, 8'h00, 8'h00};

    RESET = 1'b1; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
    A = 4'h0; DB_in = 8'h00; dreq = 4'h0; upd = 1'b0; upd_ch = 2'd0;
    temp_ld = 1'b0; temp_din = 8'h00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    check("rst_mask", {24'd0, regs_if.maskReg}, 32'h0F);
    check("rst_bp", {31'd0, dut.w_bp}, 32'd0);
    check("rst_cmd", {24'd0, regs_if.commandReg}, 32'h00);
    check("idle_oe", {31'd0, DB_oe}, 32'd0);
    check("idle_dbout", {24'd0, DB_out}, 32'h00);
    cpu_read("rst_status", 4'h8, 8'h00);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) cpu_write(tbl[i].a, tbl[i].d, 1'b0, 2'd0);
      else cpu_read($sformatf("tbl_rd%0d", i), tbl[i].a, tbl[i].exp);
    end
    check("ch0_base_addr", {16'd0, regs_if.baseAddrReg[0]}, 32'h1234);
    check("ch0_curr_addr", {16'd0, regs_if.currAddrReg[0]}, 32'h1234);
    check("ch0_curr_word", {16'd0, regs_if.currWordReg[0]}, 32'hABCD);

    // First byte alone must not touch the channel register.
    cpu_write(4'h2, 8'h77, 1'b0, 2'd0);
    check("half_write_curr", {16'd0, regs_if.currAddrReg[1]}, 32'h0000);
    check("half_write_bp", {31'd0, dut.w_bp}, 32'd1);
    cpu_write(4'hC, 8'h00, 1'b0, 2'd0);
    check("clr_bp", {31'd0, dut.w_bp}, 32'd0);

    // Channel 1: autoinit, increment, count 1.
    cpu_write(4'h2, 8'h00, 1'b0, 2'd0);
    cpu_write(4'h2, 8'h00, 1'b0, 2'd0);
    cpu_write(4'h3, 8'h01, 1'b0, 2'd0);
    cpu_write(4'h3, 8'h00, 1'b0, 2'd0);
    cpu_write(4'hB, 8'h11, 1'b0, 2'd0);
    cpu_write(4'hE, 8'h00, 1'b0, 2'd0);
    check("clr_mask", {24'd0, regs_if.maskReg}, 32'h00);
    pulse_upd("ch1_upd1_tc", 2'd1, 1'b0);
    check("ch1_upd1_word", {16'd0, regs_if.currWordReg[1]}, 32'h0000);
    check("ch1_upd1_addr", {16'd0, regs_if.currAddrReg[1]}, 32'h0001);
    pulse_upd("ch1_upd2_tc", 2'd1, 1'b1);
    check("ch1_status", {31'd0, regs_if.statusReg[1]}, 32'd1);
    check("ch1_reload_addr", {16'd0, regs_if.currAddrReg[1]}, 32'h0000);
    check("ch1_reload_word", {16'd0, regs_if.currWordReg[1]}, 32'h0001);
    check("ch1_mask", {31'd0, regs_if.maskReg[1]}, 32'd0);

    // Channel 2: decrement, no autoinit, count 0.
    cpu_write(4'h4, 8'h00, 1'b0, 2'd0);
    cpu_write(4'h4, 8'h00, 1'b0, 2'd0);
    cpu_write(4'h5, 8'h00, 1'b0, 2'd0);
    cpu_write(4'h5, 8'h00, 1'b0, 2'd0);
    cpu_write(4'hB, 8'h22, 1'b0, 2'd0);
    cpu_write(4'h9, 8'h06, 1'b0, 2'd0);
    check("ch2_req_set", {31'd0, regs_if.requestReg[2]}, 32'd1);
    pulse_upd("ch2_upd_tc", 2'd2, 1'b1);
    check("ch2_addr_wrap", {16'd0, regs_if.currAddrReg[2]}, 32'hFFFF);
    check("ch2_word_wrap", {16'd0, regs_if.currWordReg[2]}, 32'hFFFF);
    check("ch2_mask", {31'd0, regs_if.maskReg[2]}, 32'd1);
    check("ch2_req_clr", {31'd0, regs_if.requestReg[2]}, 32'd0);
    check("tc_status", {28'd0, regs_if.statusReg[3:0]}, 32'h6);
    cpu_read("status_rd", 4'h8, 8'h06);
    check("status_clr", {28'd0, regs_if.statusReg[3:0]}, 32'h0);

    // CPU high-byte commit to ch2 word coinciding with an update on ch2.
    cpu_write(4'h5, 8'h78, 1'b0, 2'd0);
    cpu_write(4'h5, 8'h56, 1'b1, 2'd2);
    check("coll_word", {16'd0, regs_if.currWordReg[2]}, 32'h5678);
    check("coll_base_word", {16'd0, regs_if.baseWordReg[2]}, 32'h5678);
    check("coll_addr", {16'd0, regs_if.currAddrReg[2]}, 32'hFFFF);
    check("coll_status", {28'd0, regs_if.statusReg[3:0]}, 32'h0);

    // Temporary register and DREQ mirror.
    @(negedge CLK);
    temp_ld = 1'b1; temp_din = 8'h5A;
    @(negedge CLK);
    temp_ld = 1'b0;
    cpu_read("temp_rd", 4'hD, 8'h5A);
    dreq = 4'hA;
    @(negedge CLK);
    cpu_read("dreq_status", 4'h8, 8'hA0);
    dreq = 4'h0;

    // Master clear in the middle of a word pair.
    cpu_write(4'h0, 8'hAA, 1'b0, 2'd0);
    check("mc_bp_before", {31'd0, dut.w_bp}, 32'd1);
    cpu_write(4'hD, 8'h00, 1'b0, 2'd0);
    check("mc_bp", {31'd0, dut.w_bp}, 32'd0);
    check("mc_mask", {24'd0, regs_if.maskReg}, 32'h0F);
    check("mc_mode", {26'd0, regs_if.modeReg[1]}, 32'd0);
    check("mc_curr_addr", {16'd0, regs_if.currAddrReg[0]}, 32'h0000);
    check("mc_base_word", {16'd0, regs_if.baseWordReg[2]}, 32'h0000);
    check("mc_temp", {24'd0, regs_if.tempReg}, 32'h00);
    check("mc_req", {28'd0, regs_if.requestReg}, 32'h0);
    cpu_write(4'h0, 8'h11, 1'b0, 2'd0);
    cpu_write(4'h0, 8'h22, 1'b0, 2'd0);
    check("mc_next_pair", {16'd0, regs_if.currAddrReg[0]}, 32'h2211);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
